// File: rtl/decode_stage.sv
// decode_stage: registered RV32I instruction-decode stage between fetch and execute.
//   Decodes opcode/funct3/funct7 into the execute control bundle, flags illegal
//   encodings and parks in TRAP until the hazard/branch unit flushes.
//   No X is ever driven on don't-care fields; unused controls are 0.
//
// Optional feature macro: DECODE_M_EXT_EN
//   defined   -> OP with funct7=0000001 decodes MUL..REMU (alu 16+funct3)
//   undefined -> that encoding is illegal
//
// Ports:
//   clk, rst_n             clock (rising edge), synchronous active-low reset
//   in_valid/in_ready      fetch handshake; in_instr, in_pc payload
//   flush                  kill registered entry, return to RUN
//   out_valid/out_ready    execute handshake
//   out_pc, out_instr      registered PC and instruction word
//   out_rd/rs1/rs2         register indices
//   out_alu_ctrl           ALU op (ADD=0..AND=9, EQ=10..GEU=15, M ops 16..23)
//   out_alu_srca           0 RRD1, 1 PC, 2 ZERO
//   out_alu_srcb           0 RRD2, 1 IMM
//   out_dataout_src        0 ALUY, 1 MEM, 2 PC4
//   out_regwe, out_mem_we, out_mem_re, out_mem_size
//   out_branch, out_jalr, out_jump, out_illegal
//   trap_pending           stage is in TRAP
module decode_stage #(
  parameter int unsigned XLEN      = 32,
  parameter int unsigned ALUCTRL_W = 5
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [31:0]          in_instr,
  input  logic [XLEN-1:0]      in_pc,
  input  logic                 flush,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [XLEN-1:0]      out_pc,
  output logic [31:0]          out_instr,
  output logic [4:0]           out_rd,
  output logic [4:0]           out_rs1,
  output logic [4:0]           out_rs2,
  output logic [ALUCTRL_W-1:0] out_alu_ctrl,
  output logic [1:0]           out_alu_srca,
  output logic [1:0]           out_alu_srcb,
  output logic [2:0]           out_dataout_src,
  output logic                 out_regwe,
  output logic                 out_mem_we,
  output logic                 out_mem_re,
  output logic [2:0]           out_mem_size,
  output logic                 out_branch,
  output logic                 out_jalr,
  output logic                 out_jump,
  output logic                 out_illegal,
  output logic                 trap_pending
);

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  localparam logic [1:0] SRCA_RRD1 = 2'd0;
  localparam logic [1:0] SRCA_PC   = 2'd1;
  localparam logic [1:0] SRCA_ZERO = 2'd2;
  localparam logic [1:0] SRCB_RRD2 = 2'd0;
  localparam logic [1:0] SRCB_IMM  = 2'd1;
  localparam logic [2:0] DOUT_ALUY = 3'd0;
  localparam logic [2:0] DOUT_MEM  = 3'd1;
  localparam logic [2:0] DOUT_PC4  = 3'd2;

  localparam logic [ALUCTRL_W-1:0] ALU_ADD  = ALUCTRL_W'(0);
  localparam logic [ALUCTRL_W-1:0] ALU_SUB  = ALUCTRL_W'(1);
  localparam logic [ALUCTRL_W-1:0] ALU_SLL  = ALUCTRL_W'(2);
  localparam logic [ALUCTRL_W-1:0] ALU_SLT  = ALUCTRL_W'(3);
  localparam logic [ALUCTRL_W-1:0] ALU_SLTU = ALUCTRL_W'(4);
  localparam logic [ALUCTRL_W-1:0] ALU_XOR  = ALUCTRL_W'(5);
  localparam logic [ALUCTRL_W-1:0] ALU_SRL  = ALUCTRL_W'(6);
  localparam logic [ALUCTRL_W-1:0] ALU_SRA  = ALUCTRL_W'(7);
  localparam logic [ALUCTRL_W-1:0] ALU_OR   = ALUCTRL_W'(8);
  localparam logic [ALUCTRL_W-1:0] ALU_AND  = ALUCTRL_W'(9);
  localparam logic [ALUCTRL_W-1:0] ALU_EQ   = ALUCTRL_W'(10);
  localparam logic [ALUCTRL_W-1:0] ALU_NE   = ALUCTRL_W'(11);
  localparam logic [ALUCTRL_W-1:0] ALU_LT   = ALUCTRL_W'(12);
  localparam logic [ALUCTRL_W-1:0] ALU_GE   = ALUCTRL_W'(13);
  localparam logic [ALUCTRL_W-1:0] ALU_LTU  = ALUCTRL_W'(14);
  localparam logic [ALUCTRL_W-1:0] ALU_GEU  = ALUCTRL_W'(15);
`ifdef DECODE_M_EXT_EN
  localparam logic [ALUCTRL_W-1:0] ALU_MUL  = ALUCTRL_W'(16);
  localparam logic [6:0]           F7_MEXT  = 7'b0000001;
`endif

  typedef enum logic {S_RUN, S_TRAP} state_t;

  typedef struct packed {
    logic [ALUCTRL_W-1:0] alu_ctrl;
    logic [1:0]           alu_srca;
    logic [1:0]           alu_srcb;
    logic [2:0]           dataout_src;
    logic                 regwe;
    logic                 mem_we;
    logic                 mem_re;
    logic [2:0]           mem_size;
    logic                 branch;
    logic                 jalr;
    logic                 jump;
    logic                 illegal;
  } ctrl_t;

  state_t          state_q, state_d;
  ctrl_t           dec_c, ctrl_q;
  logic            bad_c;
  logic            accept_c;
  logic            valid_q;
  logic [XLEN-1:0] pc_q;
  logic [31:0]     instr_q;
  logic [6:0]      opcode_c;
  logic [2:0]      f3_c;
  logic [6:0]      f7_c;

  assign opcode_c = in_instr[6:0];
  assign f3_c     = in_instr[14:12];
  assign f7_c     = in_instr[31:25];

  // Register-register / register-immediate ALU op; alt selects SRA over SRL
  function automatic logic [ALUCTRL_W-1:0] base_alu(input logic [2:0] f3, input logic alt);
    case (f3)
      3'd0:    base_alu = ALU_ADD;
      3'd1:    base_alu = ALU_SLL;
      3'd2:    base_alu = ALU_SLT;
      3'd3:    base_alu = ALU_SLTU;
      3'd4:    base_alu = ALU_XOR;
      3'd5:    base_alu = alt ? ALU_SRA : ALU_SRL;
      3'd6:    base_alu = ALU_OR;
      default: base_alu = ALU_AND;
    endcase
  endfunction

  // A new entry may enter when the output slot is free or being drained
  assign in_ready = (state_q == S_RUN) && !flush && (!valid_q || out_ready);
  assign accept_c = in_valid && in_ready;

  // Combinational decode of the incoming instruction
  always_comb begin
    dec_c = '0;
    bad_c = 1'b0;
    case (opcode_c)
      OPC_LUI, OPC_AUIPC: begin
        dec_c.alu_srca    = (opcode_c == OPC_LUI) ? SRCA_ZERO : SRCA_PC;
        dec_c.alu_srcb    = SRCB_IMM;
        dec_c.alu_ctrl    = ALU_ADD;
        dec_c.dataout_src = DOUT_ALUY;
        dec_c.regwe       = 1'b1;
      end
      OPC_JAL, OPC_JALR: begin
        dec_c.dataout_src = DOUT_PC4;
        dec_c.regwe       = 1'b1;
        dec_c.jump        = 1'b1;
        dec_c.jalr        = (opcode_c == OPC_JALR);
        if (opcode_c == OPC_JALR && f3_c != 3'd0) bad_c = 1'b1;
      end
      OPC_BRANCH: begin
        dec_c.alu_srca = SRCA_RRD1;
        dec_c.alu_srcb = SRCB_RRD2;
        dec_c.branch   = 1'b1;
        case (f3_c)
          3'd0:    dec_c.alu_ctrl = ALU_EQ;
          3'd1:    dec_c.alu_ctrl = ALU_NE;
          3'd4:    dec_c.alu_ctrl = ALU_LT;
          3'd5:    dec_c.alu_ctrl = ALU_GE;
          3'd6:    dec_c.alu_ctrl = ALU_LTU;
          3'd7:    dec_c.alu_ctrl = ALU_GEU;
          default: bad_c = 1'b1;
        endcase
      end
      OPC_LOAD: begin
        dec_c.alu_srca    = SRCA_RRD1;
        dec_c.alu_srcb    = SRCB_IMM;
        dec_c.alu_ctrl    = ALU_ADD;
        dec_c.mem_re      = 1'b1;
        dec_c.regwe       = 1'b1;
        dec_c.dataout_src = DOUT_MEM;
        dec_c.mem_size    = f3_c;
        if (f3_c == 3'd3 || f3_c == 3'd6 || f3_c == 3'd7) bad_c = 1'b1;
      end
      OPC_STORE: begin
        dec_c.alu_srca = SRCA_RRD1;
        dec_c.alu_srcb = SRCB_IMM;
        dec_c.alu_ctrl = ALU_ADD;
        dec_c.mem_we   = 1'b1;
        dec_c.mem_size = f3_c;
        if (f3_c > 3'd2) bad_c = 1'b1;
      end
      OPC_OPIMM: begin
        dec_c.alu_srca    = SRCA_RRD1;
        dec_c.alu_srcb    = SRCB_IMM;
        dec_c.dataout_src = DOUT_ALUY;
        dec_c.regwe       = 1'b1;
        dec_c.alu_ctrl    = base_alu(f3_c, f7_c == F7_ALT);
        // Only the shift immediates constrain funct7
        if (f3_c == 3'd1 && f7_c != F7_BASE) bad_c = 1'b1;
        if (f3_c == 3'd5 && f7_c != F7_BASE && f7_c != F7_ALT) bad_c = 1'b1;
      end
      OPC_OP: begin
        dec_c.alu_srca    = SRCA_RRD1;
        dec_c.alu_srcb    = SRCB_RRD2;
        dec_c.dataout_src = DOUT_ALUY;
        dec_c.regwe       = 1'b1;
        case (f7_c)
          F7_BASE: dec_c.alu_ctrl = base_alu(f3_c, 1'b0);
          F7_ALT: begin
            if (f3_c == 3'd0)      dec_c.alu_ctrl = ALU_SUB;
            else if (f3_c == 3'd5) dec_c.alu_ctrl = ALU_SRA;
            else                   bad_c = 1'b1;
          end
`ifdef DECODE_M_EXT_EN
          F7_MEXT: dec_c.alu_ctrl = ALU_MUL + ALUCTRL_W'(f3_c);
`endif
          default: bad_c = 1'b1;
        endcase
      end
      default: bad_c = 1'b1;
    endcase
    if (in_instr[1:0] != 2'b11) bad_c = 1'b1;
    // Illegal entries carry no side effects downstream
    if (bad_c) begin
      dec_c         = '0;
      dec_c.illegal = 1'b1;
    end
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= S_RUN;
    else        state_q <= state_d;
  end

  // FSM next state: flush wins, an accepted illegal entry traps
  always_comb begin
    state_d = state_q;
    if (flush)                        state_d = S_RUN;
    else if (accept_c && dec_c.illegal) state_d = S_TRAP;
  end

  // Output entry register: flush > accept > consume
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      pc_q    <= '0;
      instr_q <= '0;
      ctrl_q  <= '0;
    end else if (flush) begin
      valid_q <= 1'b0;
    end else if (accept_c) begin
      valid_q <= 1'b1;
      pc_q    <= in_pc;
      instr_q <= in_instr;
      ctrl_q  <= dec_c;
    end else if (out_ready) begin
      valid_q <= 1'b0;
    end
  end

  assign out_valid       = valid_q;
  assign out_pc          = pc_q;
  assign out_instr       = instr_q;
  assign out_rd          = instr_q[11:7];
  assign out_rs1         = instr_q[19:15];
  assign out_rs2         = instr_q[24:20];
  assign out_alu_ctrl    = ctrl_q.alu_ctrl;
  assign out_alu_srca    = ctrl_q.alu_srca;
  assign out_alu_srcb    = ctrl_q.alu_srcb;
  assign out_dataout_src = ctrl_q.dataout_src;
  assign out_regwe       = ctrl_q.regwe;
  assign out_mem_we      = ctrl_q.mem_we;
  assign out_mem_re      = ctrl_q.mem_re;
  assign out_mem_size    = ctrl_q.mem_size;
  assign out_branch      = ctrl_q.branch;
  assign out_jalr        = ctrl_q.jalr;
  assign out_jump        = ctrl_q.jump;
  assign out_illegal     = ctrl_q.illegal;
  assign trap_pending    = (state_q == S_TRAP);

endmodule

// File: tb/tb_decode_stage.sv
// Testbench for decode_stage: directed vectors, expected entries queued at
// issue time and checked by an independent monitor when execute consumes them.
module tb_decode_stage;

  logic        clk = 1'b0;
  logic        rst_n, in_valid, in_ready, flush, out_valid, out_ready;
  logic [31:0] in_instr, in_pc, out_pc, out_instr;
  logic [4:0]  out_rd, out_rs1, out_rs2, out_alu_ctrl;
  logic [1:0]  out_alu_srca, out_alu_srcb;
  logic [2:0]  out_dataout_src, out_mem_size;
  logic        out_regwe, out_mem_we, out_mem_re, out_branch, out_jalr, out_jump;
  logic        out_illegal, trap_pending;

  always #5 clk = ~clk;

  decode_stage #(.XLEN(32), .ALUCTRL_W(5)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
    .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_instr(out_instr),
    .out_rd(out_rd), .out_rs1(out_rs1), .out_rs2(out_rs2),
    .out_alu_ctrl(out_alu_ctrl), .out_alu_srca(out_alu_srca), .out_alu_srcb(out_alu_srcb),
    .out_dataout_src(out_dataout_src), .out_regwe(out_regwe),
    .out_mem_we(out_mem_we), .out_mem_re(out_mem_re), .out_mem_size(out_mem_size),
    .out_branch(out_branch), .out_jalr(out_jalr), .out_jump(out_jump),
    .out_illegal(out_illegal), .trap_pending(trap_pending)
  );

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [4:0]  rd, rs1, rs2;
    logic [4:0]  alu;
    logic [1:0]  srca, srcb;
    logic [2:0]  dout;
    logic        regwe, mem_we, mem_re;
    logic [2:0]  size;
    logic        branch, jalr, jump, illegal;
  } exp_t;

  exp_t act;
  assign act = {out_pc, out_instr, out_rd, out_rs1, out_rs2, out_alu_ctrl,
                out_alu_srca, out_alu_srcb, out_dataout_src, out_regwe,
                out_mem_we, out_mem_re, out_mem_size, out_branch, out_jalr,
                out_jump, out_illegal};

  exp_t exp_q[$];
  int   checks = 0;
  int   fails  = 0;

  task automatic chk(input string name, input logic [127:0] a, input logic [127:0] e);
    checks++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, a, e);
    end
  endtask

  function automatic exp_t mk(input logic [31:0] pc, input logic [31:0] instr,
                              input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                              input logic [4:0] alu, input logic [1:0] srca, input logic [1:0] srcb,
                              input logic [2:0] dout, input logic regwe, input logic mem_we,
                              input logic mem_re, input logic [2:0] size, input logic branch,
                              input logic jalr, input logic jump, input logic illegal);
    exp_t e;
    e = '{pc:pc, instr:instr, rd:rd, rs1:rs1, rs2:rs2, alu:alu, srca:srca, srcb:srcb,
          dout:dout, regwe:regwe, mem_we:mem_we, mem_re:mem_re, size:size,
          branch:branch, jalr:jalr, jump:jump, illegal:illegal};
    return e;
  endfunction

  // Monitor: every consumed entry must match the oldest expectation
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        fails++;
        $display("FAIL unexpected_entry: got %0h expected none", act);
      end else begin
        chk("entry", 128'(act), 128'(exp_q.pop_front()));
      end
    end
  end

  // Present one instruction until accepted (bounded); returns 1 time unit after the accept edge
  task automatic send(input logic [31:0] instr, input logic [31:0] pc, input exp_t e);
    int n = 0;
    in_valid = 1'b1;
    in_instr = instr;
    in_pc    = pc;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("send_accept", 128'(in_ready), 128'(1));
    if (in_ready) exp_q.push_back(e);
    else          in_valid = 1'b0;
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  // Flush pulse with a competing instruction that must not be accepted
  task automatic do_flush();
    @(posedge clk);
    #1 flush = 1'b1;
    in_valid = 1'b1;
    in_instr = 32'h00002023;
    @(negedge clk);
    chk("flush_in_ready", 128'(in_ready), 128'(0));
    @(posedge clk);
    #1 flush = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    chk("flush_out_valid", 128'(out_valid), 128'(0));
    chk("flush_trap", 128'(trap_pending), 128'(0));
    chk("flush_in_ready_after", 128'(in_ready), 128'(1));
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  exp_t e_add, e_sub;

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_instr = '0; in_pc = '0;
    flush = 1'b0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_outputs", 128'({out_valid, act}), 128'(0));
    chk("reset_trap", 128'(trap_pending), 128'(0));
    chk("reset_in_ready", 128'(in_ready), 128'(1));
    @(posedge clk);
    #1 rst_n = 1'b1;

    // ADDI x1,x0,5
    send(32'h00500093, 32'h100, mk(32'h100, 32'h00500093, 1, 0, 5, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0));
    @(negedge clk);
    chk("addi_valid", 128'(out_valid), 128'(1));
    chk("addi_in_ready", 128'(in_ready), 128'(1));
    @(posedge clk);
    #1 out_ready = 1'b0;

    // ADD then SUB under a 3-cycle stall
    e_add = mk(32'h104, 32'h00208133, 2, 1, 2, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
    e_sub = mk(32'h108, 32'h40208133, 2, 1, 2, 1, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
    send(32'h00208133, 32'h104, e_add);
    fork
      send(32'h40208133, 32'h108, e_sub);
      begin
        repeat (3) begin
          @(negedge clk);
          chk("stall_hold", 128'({out_valid, act}), 128'({1'b1, e_add}));
          chk("stall_in_ready", 128'(in_ready), 128'(0));
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("sub_follows", 128'({out_valid, out_alu_ctrl}), 128'({1'b1, 5'd1}));
      end
    join
    @(posedge clk);
    #1;

    // All-zero word: illegal, traps
    send(32'h00000000, 32'h10c, mk(32'h10c, 32'h0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
    @(negedge clk);
    chk("trap_pending", 128'(trap_pending), 128'(1));
    chk("trap_in_ready", 128'(in_ready), 128'(0));
    chk("trap_flags", 128'({out_illegal, out_regwe, out_mem_we, out_mem_re, out_branch, out_jump, out_jalr}),
        128'(7'b1000000));
    @(negedge clk);
    chk("trap_drained", 128'({out_valid, trap_pending}), 128'(2'b01));
    do_flush();

    // SW accepted right after flush, then illegal LW funct3=3
    send(32'h00002023, 32'h110, mk(32'h110, 32'h00002023, 0, 0, 0, 0, 0, 1, 0, 0, 1, 0, 2, 0, 0, 0, 0));
    send(32'h00003003, 32'h114, mk(32'h114, 32'h00003003, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
    @(negedge clk);
    chk("load_f3_trap", 128'(trap_pending), 128'(1));
    @(negedge clk);
    do_flush();

    // OP funct7=0000001
`ifdef DECODE_M_EXT_EN
    send(32'h02208033, 32'h118, mk(32'h118, 32'h02208033, 0, 1, 2, 16, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0));
    @(negedge clk);
    chk("mext_no_trap", 128'(trap_pending), 128'(0));
    @(posedge clk);
    #1;
`else
    send(32'h02208033, 32'h118, mk(32'h118, 32'h02208033, 0, 1, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
    @(negedge clk);
    chk("mext_trap", 128'(trap_pending), 128'(1));
    @(negedge clk);
    do_flush();
`endif

    // Back-to-back opcode coverage: LUI, AUIPC, JAL, BEQ, BLTU, SRAI
    send(32'h123450b7, 32'h120, mk(32'h120, 32'h123450b7, 1, 8, 3, 0, 2, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0));
    send(32'h00001117, 32'h124, mk(32'h124, 32'h00001117, 2, 0, 0, 0, 1, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0));
    send(32'h008000ef, 32'h128, mk(32'h128, 32'h008000ef, 1, 0, 8, 0, 0, 0, 2, 1, 0, 0, 0, 0, 0, 1, 0));
    send(32'h00208463, 32'h12c, mk(32'h12c, 32'h00208463, 8, 1, 2, 10, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0));
    send(32'h0020e463, 32'h130, mk(32'h130, 32'h0020e463, 8, 1, 2, 14, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0));
    send(32'h4020d093, 32'h134, mk(32'h134, 32'h4020d093, 1, 1, 2, 7, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0));
    @(posedge clk);
    #1 out_ready = 1'b0;

    // SLLI with funct7=0100000: illegal, held in TRAP, then reset
    send(32'h40209093, 32'h138, mk(32'h138, 32'h40209093, 1, 1, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
    @(negedge clk);
    chk("slli_trap_stall", 128'({out_valid, out_illegal, trap_pending}), 128'(3'b111));
    @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk);
    exp_q.delete();
    @(negedge clk);
    chk("trap_reset_outputs", 128'({out_valid, act}), 128'(0));
    chk("trap_reset_state", 128'({trap_pending, in_ready}), 128'(2'b01));
    @(posedge clk);
    #1 rst_n = 1'b1;
    out_ready = 1'b1;
    send(32'h00500093, 32'h200, mk(32'h200, 32'h00500093, 1, 0, 5, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0));
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("queue_drained", 128'(exp_q.size()), 128'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
Registered instruction-decode stage for the RV32I pipeline, placed between fetch and execute.
- Decodes opcode, funct3 and funct7 into the full execute control bundle, including the ALU operation.
- Detects illegal encodings and enters a trap-hold state.
- Talks to both neighbours over valid/ready handshakes; flush comes from the hazard/branch unit.
- Unlike the combinational main decoder, it drives no X on don't-care fields.

Parameters:
XLEN, 32, width of PC fields.
ALUCTRL_W, 5, width of out_alu_ctrl (must be >= 5).

Ports:
clk  in  1  clock, rising edge.
rst_n  in  1  synchronous active-low reset.
in_valid  in  1  fetch presents an instruction.
in_ready  out  1  stage accepts an instruction this cycle.
in_instr  in  32  instruction word.
in_pc  in  XLEN  instruction PC.
flush  in  1  kill the registered entry and leave TRAP.
out_valid  out  1  decoded entry valid.
out_ready  in  1  execute consumes the entry.
out_pc  out  XLEN  registered PC.
out_instr  out  32  registered instruction (immediate generation downstream).
out_rd, out_rs1, out_rs2  out  5 each  register indices (instr[11:7], [19:15], [24:20]).
out_alu_ctrl  out  ALUCTRL_W  ALU operation code.
out_alu_srca  out  2  `EXE_ALUSRCA_* select.
out_alu_srcb  out  2  `EXE_ALUSRCB_* select.
out_dataout_src  out  3  `EXE_DATAOUTSRC_* select.
out_regwe  out  1  register write enable.
out_mem_we  out  1  data-memory write.
out_mem_re  out  1  data-memory read.
out_mem_size  out  3  funct3 for loads and stores, otherwise 0.
out_branch, out_jalr, out_jump  out  1 each  control-flow flags.
out_illegal  out  1  entry is an illegal instruction.
trap_pending  out  1  FSM is in TRAP.

Behaviour:
- Reset (rst_n=0 at a clk edge): out_valid=0, every out_* field=0, state=RUN, trap_pending=0.
- Handshake
  - in_ready = (state==RUN) && !flush && (!out_valid || out_ready).
  - Accept occurs when in_valid && in_ready; the decoded entry appears on outputs the next cycle. Latency 1; throughput 1 per cycle.
  - out_valid && !out_ready: all out_* fields hold stable.
  - Consume without a new accept: out_valid falls to 0 next cycle.
- ALU codes:
  - RV32I: ADD=0, SUB=1, SLL=2, SLT=3, SLTU=4, XOR=5, SRL=6, SRA=7, OR=8, AND=9.
  - Branch compares: EQ=10, NE=11, LT=12, GE=13, LTU=14, GEU=15.
  - M-extension: 16..23.
- Per-opcode decode (any field not listed is 0):
  - LUI: srca ZERO, srcb IMM, alu ADD, dataout ALUY, regwe 1.
  - AUIPC: same as LUI but srca PC.
  - JAL: dataout PC4, regwe 1, jump 1.
  - JALR: as JAL plus jalr 1; funct3 must be 0.
  - BRANCH: srca RRD1, srcb RRD2, branch 1, alu from funct3; funct3 2 or 3 is illegal.
  - LOAD: srca RRD1, srcb IMM, alu ADD, mem_re 1, regwe 1, dataout MEM, mem_size=funct3; funct3 3, 6, 7 are illegal.
  - STORE: srca RRD1, srcb IMM, alu ADD, mem_we 1, mem_size=funct3; funct3 > 2 is illegal.
  - OP-IMM: srca RRD1, srcb IMM, dataout ALUY, regwe 1, alu from funct3.
    - SLLI requires funct7=0000000.
    - SRLI/SRAI require funct7 0000000 or 0100000.
  - OP: srca RRD1, srcb RRD2, dataout ALUY, regwe 1.
    - funct7 0000000: any funct3.
    - funct7 0100000: only funct3 000 (SUB) and 101 (SRA).
    - Any other funct7 is illegal (see Optional Feature).
- Illegal conditions: instr[1:0] != 2'b11, an unknown opcode, or any illegal field combination above.
  - Entry is registered with out_illegal=1 and regwe, mem_we, mem_re, branch, jump, jalr all 0.
  - State goes RUN->TRAP on the accept edge.
- TRAP state: in_ready=0 and trap_pending=1. The illegal entry is presented until consumed; afterwards out_valid=0. State stays TRAP until flush.
- flush=1:
  - Next edge: out_valid=0, state=RUN.
  - No accept occurs in the flush cycle.
  - flush outranks stall and accept.
- Reset while in TRAP or while stalled behaves identically to power-on reset.

Optional Feature:
Macro DECODE_M_EXT_EN.
- Defined: OP with funct7=0000001 decodes as MUL..REMU; alu = 16 + funct3, srca RRD1, srcb RRD2, dataout ALUY, regwe 1.
- Undefined: funct7=0000001 is illegal and enters TRAP.

Test Plan:
- Reset, then 0x00500093 (ADDI x1,x0,5) with out_ready=1 -> next cycle out_valid=1, alu=0, srcb IMM, regwe=1, rd=1, pc echoed; in_ready stays 1.
- Back-to-back 0x00208133 (ADD) then 0x40208133 (SUB) with out_ready=0 for 3 cycles -> ADD entry held stable, in_ready=0; after out_ready=1, SUB (alu=1) follows one cycle later.
- 0x00000000 -> out_illegal=1, all write and jump flags 0, trap_pending=1, in_ready=0; flush pulse -> out_valid=0 next cycle, trap_pending=0, next instruction accepted the cycle after.
- 0x00003003 (load funct3=3) -> illegal; 0x00002023 (SW) -> mem_we=1, mem_size=2, regwe=0.
- 0x02208033 -> with DECODE_M_EXT_EN: alu=16, regwe=1, not illegal; without the macro: out_illegal=1, TRAP.
- rst_n=0 for one edge while stalled in TRAP -> out_valid=0, all outputs 0, state RUN, in_ready=1 next cycle.
